// File: rtl/recip_nr_seq.sv
// ---------------------------------------------------------------------------
// recip_nr_seq
//   Sequenced Newton-Raphson reciprocal of an unsigned Q8.24 operand.
//   Result Y ~= 2^48 / X in Q8.24 (1.0 = 0x0100_0000). One 32x32 multiplier
//   is shared by the seed evaluation and every iteration step.
//
// Parameters
//   ITERS : Newton-Raphson iterations (1..4), two multiply cycles each
//   W     : operand/result width, fixed at 32 (Q8.24)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand valid
//   in_ready   block is idle and can accept an operand
//   in_x       operand X, Q8.24 unsigned
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   out_y      result Y, Q8.24 unsigned
//   out_sat    (RECIP_SAT_FLAG_EN only) result saturated, valid with out_valid
//
// Build option
//   RECIP_SAT_FLAG_EN : adds the out_sat port.
// ---------------------------------------------------------------------------
module recip_nr_seq #(
  parameter int ITERS = 3,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y
`ifdef RECIP_SAT_FLAG_EN
  ,
  output logic         out_sat
`endif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] NORM   = 3'd1;
  localparam logic [2:0] MUL_A  = 3'd2;
  localparam logic [2:0] MUL_B  = 3'd3;
  localparam logic [2:0] DENORM = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  // Linear seed y0 = 48/17 - 32/17*m, both constants in Q2.30.
  localparam logic [W-1:0] Y0_ICPT  = 32'hB4B4_B4B4;
  localparam logic [W-1:0] Y0_SLOPE = 32'h7878_7878;
  localparam logic [W-1:0] TWO_Q30  = 32'h8000_0000;
  localparam logic [W-1:0] SAT_LIM  = 32'h0001_0000;
  localparam logic [W-1:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [2:0]   LAST_IT  = 3'(ITERS - 1);

  logic [2:0]     state;
  logic [2:0]     it_cnt;
  logic [W-1:0]   x_q;
  logic [W-1:0]   m_q;
  logic [W-1:0]   y_q;
  logic [W-1:0]   e_q;
  logic [4:0]     p_q;
  logic           sat_q;

  logic [4:0]     p_n;
  logic [W-1:0]   m_norm;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] prod;
  logic [W:0]     dn;

  // Position of the most significant set bit; zero input gives 0, but that
  // case is always routed through the saturation path.
  function automatic logic [4:0] lead_one(input logic [W-1:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

  // Scale the Q2.30 reciprocal of m back to Q8.24: out = y * 2^(17-p).
  // Returns {overflow, value}; overflow saturates to all ones.
  function automatic logic [W:0] denorm(input logic [W-1:0] y,
                                        input logic [4:0]   p);
    logic [2*W-1:0] wide;
    logic [4:0]     sh;
    logic [W:0]     r;
    wide = '0;
    sh   = 5'd0;
    r    = '0;
    if (p < 5'd17) begin
      sh   = 5'd17 - p;
      wide = {{W{1'b0}}, y} << sh;
      if (wide[2*W-1:W] != '0) r = {1'b1, ALL_ONES};
      else                     r = {1'b0, wide[W-1:0]};
    end else begin
      sh = p - 5'd17;
      r  = {1'b0, y >> sh};
    end
    return r;
  endfunction

  assign in_ready = rst_n && (state == IDLE);

  assign p_n    = lead_one(x_q);
  assign m_norm = x_q << (5'd31 - p_n);
  assign dn     = denorm(y_q, p_q);

  // Shared multiplier operand select.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      NORM:    begin mul_a = m_norm; mul_b = Y0_SLOPE; end
      MUL_A:   begin mul_a = m_q;    mul_b = y_q;      end
      MUL_B:   begin mul_a = y_q;    mul_b = e_q;      end
      default: begin mul_a = '0;     mul_b = '0;       end
    endcase
  end

  assign prod = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      it_cnt    <= '0;
      x_q       <= '0;
      m_q       <= '0;
      y_q       <= '0;
      e_q       <= '0;
      p_q       <= '0;
      sat_q     <= 1'b0;
      out_y     <= '0;
      out_valid <= 1'b0;
`ifdef RECIP_SAT_FLAG_EN
      out_sat   <= 1'b0;
`endif
    end else begin
      case (state)
        // Stage: operand capture
        IDLE: begin
          if (in_valid) begin
            x_q   <= in_x;
            state <= NORM;
          end
        end
        // Stage: normalise to m in [0.5,1) and form the linear seed
        NORM: begin
          p_q    <= p_n;
          m_q    <= m_norm;
          y_q    <= Y0_ICPT - W'(prod >> 32);
          it_cnt <= '0;
          sat_q  <= (x_q <= SAT_LIM);
          state  <= (x_q <= SAT_LIM) ? DENORM : MUL_A;
        end
        // Stage: error term e = 2 - m*y (Q2.30)
        MUL_A: begin
          e_q   <= TWO_Q30 - W'(prod >> 32);
          state <= MUL_B;
        end
        // Stage: refined estimate y = y*e (Q2.30)
        MUL_B: begin
          y_q    <= W'(prod >> 30);
          it_cnt <= it_cnt + 3'd1;
          state  <= (it_cnt == LAST_IT) ? DENORM : MUL_A;
        end
        // Stage: rescale to Q8.24 with saturation
        DENORM: begin
          out_y     <= sat_q ? ALL_ONES : dn[W-1:0];
          out_valid <= 1'b1;
`ifdef RECIP_SAT_FLAG_EN
          out_sat   <= sat_q | dn[W];
`endif
          state     <= DONE;
        end
        // Stage: hold result until the consumer takes it
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recip_nr_seq.sv
// ---------------------------------------------------------------------------
// tb_recip_nr_seq
//   Self-checking bench for recip_nr_seq. Results are compared with
//   floor(2^48/X) computed by plain 64-bit division (+-4 LSB), saturating
//   operands X <= 0x0001_0000 must give exactly 0xFFFF_FFFF.
//   Define RECIP_SAT_FLAG_EN to also exercise out_sat.
// ---------------------------------------------------------------------------
module tb_recip_nr_seq;

  localparam int ITERS = 3;
  localparam int LAT   = 2 * ITERS + 2;
  localparam int NRAND = 1000;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
`ifdef RECIP_SAT_FLAG_EN
  logic        out_sat;
`endif

  int checks = 0;
  int errors = 0;

  recip_nr_seq #(.ITERS(ITERS), .W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y)
`ifdef RECIP_SAT_FLAG_EN
    ,
    .out_sat   (out_sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_recip(input logic [31:0] x);
    logic [63:0] q;
    if (x <= 32'h0001_0000) return 32'hFFFF_FFFF;
    q = 64'h0001_0000_0000_0000 / {32'h0, x};
    if (q > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
    return q[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_y(input string tag, input logic [31:0] x,
                       input logic [31:0] y);
    logic [31:0] r;
    logic        ok;
    r = ref_recip(x);
    if (x <= 32'h0001_0000) ok = (y === 32'hFFFF_FFFF);
    else                    ok = (((y >= r) ? (y - r) : (r - y)) <= 32'd4);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: x=%h observed out_y=%h expected %h +-4", tag, x, y, r);
    end
  endtask

  // One full transaction with out_ready held high.
  task automatic do_op(input string tag, input logic [31:0] x,
                       input int exp_lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
    in_x     = x;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk_y(tag, x, out_y);
`ifdef RECIP_SAT_FLAG_EN
    chk({tag, " out_sat"}, {31'b0, out_sat}, {31'b0, (x <= 32'h0001_0000)});
`endif
    tick();
    chk({tag, " out_valid clear"}, {31'b0, out_valid}, 32'd0);
  endtask

  logic [31:0] dir_x [14] = '{32'h0019_999A, 32'h004C_CCCD, 32'h0080_0000,
                              32'h00B3_3333, 32'h01CC_CCCD, 32'h0280_0000,
                              32'h0300_0000, 32'h0200_0000, 32'h0000_0000,
                              32'h0001_0000, 32'h0001_0001, 32'hFFFF_FFFF,
                              32'h0002_0000, 32'h0000_0001};

  logic [31:0] exp_q[$];
  logic [31:0] xr;
  logic        stale;
  int          n;
  int          sent;
  int          recv;
  int          cyc;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst out_y", out_y, 32'd0);
`ifdef RECIP_SAT_FLAG_EN
    chk("rst out_sat", {31'b0, out_sat}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    chk("post-rst in_ready", {31'b0, in_ready}, 32'd1);

    // 1.0 and the directed operand table
    do_op("one", 32'h0100_0000, LAT);
    for (int i = 0; i < 14; i++)
      do_op($sformatf("dir%0d", i), dir_x[i],
            (dir_x[i] <= 32'h0001_0000) ? 2 : LAT);

    // Back-pressure: result held, no accept while DONE
    out_ready = 1'b0;
    in_x      = 32'h0200_0000;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("bp latency", 32'(n), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_x     = 32'h0300_0000;
      chk("bp out_valid held", {31'b0, out_valid}, 32'd1);
      chk("bp in_ready low", {31'b0, in_ready}, 32'd0);
      chk_y("bp out_y held", 32'h0200_0000, out_y);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp release out_valid", {31'b0, out_valid}, 32'd0);
    chk("bp release in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("bp next latency", 32'(n), 32'(LAT));
    chk_y("bp next", 32'h0300_0000, out_y);
    tick();

    // Reset while in MUL_B
    in_x     = 32'h0300_0000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst release in_ready", {31'b0, in_ready}, 32'd1);
    stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      stale = stale | out_valid;
    end
    chk("midrst no stale result", {31'b0, stale}, 32'd0);

    // Reset while a result is pending
    out_ready = 1'b0;
    in_x      = 32'h0080_0000;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("donerst latency", 32'(n), 32'(LAT));
    rst_n = 1'b0;
    #1;
    chk("donerst out_valid", {31'b0, out_valid}, 32'd0);
    chk("donerst out_y", out_y, 32'd0);
    chk("donerst in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("donerst release in_ready", {31'b0, in_ready}, 32'd1);
    do_op("after rst", 32'h0100_0000, LAT);

    // Random operands with random gaps on both sides
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < NRAND && cyc < 40000) begin
      case ($urandom_range(0, 3))
        0:       xr = $urandom;
        1:       xr = $urandom_range(32'h0001_0001, 32'h01FF_FFFF);
        2:       xr = 32'h0000_FFF8 + $urandom_range(0, 16);
        default: xr = $urandom >> $urandom_range(0, 31);
      endcase
      in_x      = xr;
      in_valid  = (sent < NRAND) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(xr);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          assert (1'b0 === 1'b1) else begin
            errors++;
            $error("FAIL rand dup: result %h with no outstanding operand", out_y);
          end
        end else begin
          chk_y("rand", exp_q.pop_front(), out_y);
        end
        recv++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rand results received", 32'(recv), 32'(NRAND));
    chk("rand operands sent", 32'(sent), 32'(NRAND));
    chk("rand queue drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
